// File: rtl/keypad_scanner_if.sv
// Debounced key bus from the keypad scanner to the vending-machine control logic.
interface keypad_scanner_if;
    logic [2:0] coluna;
    logic [3:0] linha;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_strobe;

    // Scanner side drives the bus.
    modport master (
        output coluna,
        output linha,
        output key_code,
        output key_valid,
        output key_strobe
    );

    // Control logic side consumes the bus.
    modport slave (
        input coluna,
        input linha,
        input key_code,
        input key_valid,
        input key_strobe
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: one-hot row drive, column sampling at the end of
// each row dwell, multi-key rejection and frame-based press/release debounce.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 16,
    parameter int unsigned DEBOUNCE_FRAMES = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        coluna_in,
    output logic [3:0]        linha_out,
    keypad_scanner_if.master  key_bus
);

    localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_TARGET = CNT_W'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [3:0]         row_q;
    logic               acc_hit_q, acc_inv_q;
    logic [3:0]         acc_row_q;
    logic [2:0]         acc_col_q;
    logic [3:0]         cand_row_q, cand_row_d;
    logic [2:0]         cand_col_q, cand_col_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [2:0]         col_q, col_d;
    logic [3:0]         lin_q, lin_d;
    logic [3:0]         code_q, code_d;
    logic               valid_q, valid_d;
    logic               strobe_q, strobe_d;

    logic       last_dwell, frame_end;
    logic       sample_nz, sample_onehot;
    logic       hit_now, inv_now, res_key, same_key;
    logic [3:0] key_row_now;
    logic [2:0] key_col_now;

    // Keypad code for a one-hot row/column pair.
    function automatic logic [3:0] encode(input logic [3:0] r, input logic [2:0] c);
        logic [3:0] ri, ci;
        ri = r[3] ? 4'd0 : r[2] ? 4'd1 : r[1] ? 4'd2 : 4'd3;
        ci = c[2] ? 4'd0 : c[1] ? 4'd1 : 4'd2;
        if (ri != 4'd3) begin
            encode = 4'(ri * 4'd3 + ci + 4'd1);
        end else begin
            encode = (ci == 4'd0) ? 4'd10 : (ci == 4'd1) ? 4'd0 : 4'd11;
        end
    endfunction

    assign last_dwell    = (dwell_q == DWELL_LAST);
    assign frame_end     = last_dwell && (row_q == 4'b0001);
    assign sample_nz     = |coluna_in;
    assign sample_onehot = ((coluna_in & 3'(coluna_in - 3'd1)) == 3'b000);
    assign hit_now       = acc_hit_q | sample_nz;
    assign inv_now       = acc_inv_q | (sample_nz & (acc_hit_q | ~sample_onehot));
    assign key_row_now   = sample_nz ? row_q : acc_row_q;
    assign key_col_now   = sample_nz ? coluna_in : acc_col_q;
    assign res_key       = hit_now & ~inv_now;
    assign same_key      = res_key && (key_row_now == cand_row_q) && (key_col_now == cand_col_q);
    assign cnt_inc       = (&cnt_q) ? cnt_q : CNT_W'(cnt_q + CNT_W'(1));

    // Row rotation, dwell timing and per-frame accumulation of column samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            dwell_q   <= '0;
            row_q     <= 4'b1000;
            acc_hit_q <= 1'b0;
            acc_inv_q <= 1'b0;
            acc_row_q <= '0;
            acc_col_q <= '0;
        end else if (last_dwell) begin
            dwell_q <= '0;
            row_q   <= {row_q[0], row_q[3:1]};
            if (frame_end) begin
                acc_hit_q <= 1'b0;
                acc_inv_q <= 1'b0;
                acc_row_q <= '0;
                acc_col_q <= '0;
            end else begin
                acc_hit_q <= hit_now;
                acc_inv_q <= inv_now;
                acc_row_q <= key_row_now;
                acc_col_q <= key_col_now;
            end
        end else begin
            dwell_q <= DWELL_W'(dwell_q + DWELL_W'(1));
        end
    end

    // Debounce state, candidate key and registered key outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_row_q <= '0;
            cand_col_q <= '0;
            col_q      <= '0;
            lin_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            col_q      <= col_d;
            lin_q      <= lin_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
        end
    end

    // Frame-end transitions; outputs load on press acceptance, clear on return to IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        col_d      = col_q;
        lin_d      = lin_q;
        code_d     = code_q;
        valid_d    = valid_q;
        strobe_d   = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (res_key) begin
                        cand_row_d = key_row_now;
                        cand_col_d = key_col_now;
                        cnt_d      = CNT_W'(1);
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d  = PRESSED;
                            col_d    = key_col_now;
                            lin_d    = key_row_now;
                            code_d   = encode(key_row_now, key_col_now);
                            valid_d  = 1'b1;
                            strobe_d = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (same_key) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_TARGET) begin
                            state_d  = PRESSED;
                            col_d    = cand_col_q;
                            lin_d    = cand_row_q;
                            code_d   = encode(cand_row_q, cand_col_q);
                            valid_d  = 1'b1;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (!same_key) begin
                        if ((DEBOUNCE_FRAMES == 1) && !res_key) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            col_d   = '0;
                            lin_d   = '0;
                            code_d  = '0;
                            valid_d = 1'b0;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = res_key ? CNT_W'(0) : CNT_W'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (!res_key) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_TARGET) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            col_d   = '0;
                            lin_d   = '0;
                            code_d  = '0;
                            valid_d = 1'b0;
                        end
                    end else if (same_key) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign linha_out          = row_q;
    assign key_bus.coluna     = col_q;
    assign key_bus.linha      = lin_q;
    assign key_bus.key_code   = code_q;
    assign key_bus.key_valid  = valid_q;
    assign key_bus.key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frame).
module tb_keypad_scanner;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  coluna_in;
    logic [3:0]  linha_out;
    logic [11:0] pressed;
    int          cyc;
    int          strobe_cnt;
    int          tests;
    int          fails;

    keypad_scanner_if kb();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .coluna_in (coluna_in),
        .linha_out (linha_out),
        .key_bus   (kb)
    );

    always #5 clock = ~clock;

    // Keypad matrix: key k sits at row k/3, column k%3 and only answers while its row is driven.
    always_comb begin
        coluna_in = 3'b000;
        for (int k = 0; k < 12; k++) begin
            if (pressed[k] && (linha_out == 4'(4'b1000 >> (k / 3))))
                coluna_in = coluna_in | 3'(3'b100 >> (k % 3));
        end
    end

    // Cycle index since reset; frames start where cyc is a multiple of 16.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Count strobe cycles (sampled with pre-edge values).
    always @(posedge clock) begin
        if (kb.key_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;
    end

    typedef struct {
        int         pos;
        logic [3:0] code;
        logic [2:0] col;
        logic [3:0] row;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic goto_frame_start();
        while ((cyc % 16) != 0) tick();
    endtask

    // Press one key at a frame start and check the strobe lands after the 3rd frame end.
    task automatic press_check(input int pos, input logic [3:0] code, input logic [2:0] col,
                               input logic [3:0] row, input string name);
        int base;
        int s0;
        goto_frame_start();
        base    = cyc;
        s0      = strobe_cnt;
        pressed = 12'b1 << pos;
        run_until(base + 47);
        check({name, " no early strobe"}, 32'(strobe_cnt - s0), 32'd0);
        check({name, " strobe low before accept"}, 32'(kb.key_strobe), 32'd0);
        tick();
        check({name, " strobe"}, 32'(kb.key_strobe), 32'd1);
        check({name, " key_code"}, 32'(kb.key_code), 32'(code));
        check({name, " coluna"}, 32'(kb.coluna), 32'(col));
        check({name, " linha"}, 32'(kb.linha), 32'(row));
        check({name, " key_valid"}, 32'(kb.key_valid), 32'd1);
        tick();
        check({name, " strobe one cycle"}, 32'(kb.key_strobe), 32'd0);
        check({name, " strobe count"}, 32'(strobe_cnt - s0), 32'd1);
    endtask

    // Release at a frame start; key_valid must fall exactly at the 3rd NONE frame end.
    task automatic release_check(input string name);
        int base;
        goto_frame_start();
        base    = cyc;
        pressed = '0;
        run_until(base + 47);
        check({name, " valid held until release done"}, 32'(kb.key_valid), 32'd1);
        tick();
        check({name, " valid cleared"}, 32'(kb.key_valid), 32'd0);
        check({name, " code cleared"}, 32'(kb.key_code), 32'd0);
        check({name, " coluna cleared"}, 32'(kb.coluna), 32'd0);
        check({name, " linha cleared"}, 32'(kb.linha), 32'd0);
    endtask

    initial begin
        int base;
        int s0;
        int bad;
        logic [3:0] exp_row;

        tests      = 0;
        fails      = 0;
        strobe_cnt = 0;
        pressed    = '0;

        vecs[0]  = '{0,  4'd1,  3'b100, 4'b1000};
        vecs[1]  = '{1,  4'd2,  3'b010, 4'b1000};
        vecs[2]  = '{2,  4'd3,  3'b001, 4'b1000};
        vecs[3]  = '{3,  4'd4,  3'b100, 4'b0100};
        vecs[4]  = '{4,  4'd5,  3'b010, 4'b0100};
        vecs[5]  = '{5,  4'd6,  3'b001, 4'b0100};
        vecs[6]  = '{6,  4'd7,  3'b100, 4'b0010};
        vecs[7]  = '{7,  4'd8,  3'b010, 4'b0010};
        vecs[8]  = '{8,  4'd9,  3'b001, 4'b0010};
        vecs[9]  = '{9,  4'd10, 3'b100, 4'b0001};
        vecs[10] = '{10, 4'd0,  3'b010, 4'b0001};
        vecs[11] = '{11, 4'd11, 3'b001, 4'b0001};

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        check("reset linha_out", 32'(linha_out), 32'h8);
        check("reset key_valid", 32'(kb.key_valid), 32'd0);
        check("reset key_strobe", 32'(kb.key_strobe), 32'd0);
        check("reset coluna", 32'(kb.coluna), 32'd0);
        check("reset linha", 32'(kb.linha), 32'd0);
        check("reset key_code", 32'(kb.key_code), 32'd0);

        // Idle scan: rows rotate every 4 cycles, nothing is reported.
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            exp_row = 4'(4'b1000 >> ((cyc / 4) % 4));
            if (linha_out !== exp_row || kb.key_valid !== 1'b0 || kb.coluna !== 3'b000) bad++;
            tick();
        end
        check("idle scan bad cycles", 32'(bad), 32'd0);
        check("idle no strobe", 32'(strobe_cnt), 32'd0);

        // Every key, clean press and release.
        for (int i = 0; i < 12; i++) begin
            press_check(vecs[i].pos, vecs[i].code, vecs[i].col, vecs[i].row, $sformatf("key%0d", vecs[i].code));
            release_check($sformatf("rel%0d", vecs[i].code));
        end

        // Key 0 bouncing every frame for 6 frames, then stable.
        goto_frame_start();
        base = cyc;
        s0   = strobe_cnt;
        for (int f = 0; f < 6; f++) begin
            pressed = (f % 2 == 0) ? 12'b0100_0000_0000 : 12'b0;
            run_until(base + 16 * (f + 1));
        end
        check("bounce no strobe", 32'(strobe_cnt - s0), 32'd0);
        check("bounce no valid", 32'(kb.key_valid), 32'd0);
        press_check(10, 4'd0, 3'b010, 4'b0001, "bounce key0");
        release_check("bounce rel");

        // Keys 1 and 6 together (two rows) and keys 4 and 5 together (two columns).
        goto_frame_start();
        base    = cyc;
        s0      = strobe_cnt;
        pressed = 12'b0000_0010_0001;
        run_until(base + 64);
        check("two rows no strobe", 32'(strobe_cnt - s0), 32'd0);
        check("two rows no valid", 32'(kb.key_valid), 32'd0);
        pressed = 12'b0000_0001_1000;
        run_until(base + 128);
        check("two cols no strobe", 32'(strobe_cnt - s0), 32'd0);
        check("two cols no valid", 32'(kb.key_valid), 32'd0);
        pressed = '0;
        run_until(base + 176);
        press_check(11, 4'd11, 3'b001, 4'b0001, "hash");
        release_check("hash rel");

        // Key 9 held with one NONE frame gap: no drop of key_valid, no second strobe.
        press_check(8, 4'd9, 3'b001, 4'b0010, "gap key9");
        goto_frame_start();
        base    = cyc;
        s0      = strobe_cnt;
        bad     = 0;
        pressed = '0;
        while (cyc < base + 16) begin
            if (kb.key_valid !== 1'b1) bad++;
            tick();
        end
        pressed = 12'b0001_0000_0000;
        while (cyc < base + 80) begin
            if (kb.key_valid !== 1'b1) bad++;
            tick();
        end
        check("gap valid held", 32'(bad), 32'd0);
        check("gap no second strobe", 32'(strobe_cnt - s0), 32'd0);
        check("gap code kept", 32'(kb.key_code), 32'd9);
        release_check("gap rel");

        // Reset while key 3 is pressed; re-acceptance after 3 frames.
        press_check(2, 4'd3, 3'b001, 4'b1000, "pre-reset key3");
        run_until(cyc + 21);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset valid", 32'(kb.key_valid), 32'd0);
        check("mid reset coluna", 32'(kb.coluna), 32'd0);
        check("mid reset linha_out", 32'(linha_out), 32'h8);
        check("mid reset code", 32'(kb.key_code), 32'd0);
        s0 = strobe_cnt;
        run_until(47);
        check("post reset no early strobe", 32'(strobe_cnt - s0), 32'd0);
        tick();
        check("post reset strobe", 32'(kb.key_strobe), 32'd1);
        check("post reset code", 32'(kb.key_code), 32'd3);
        check("post reset valid", 32'(kb.key_valid), 32'd1);
        pressed = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
